// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: operand/forward selects, RV-M ops,
// ALU ops, mul/div FSM states and the E/M control payload.
package execute_pkg;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] FWD_M     = 2'b01;
    localparam logic [1:0] FWD_W     = 2'b10;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_BEQ  = 4'hA;
    localparam logic [3:0] ALU_BNE  = 4'hB;
    localparam logic [3:0] ALU_BLT  = 4'hC;
    localparam logic [3:0] ALU_BGE  = 4'hD;
    localparam logic [3:0] ALU_BLTU = 4'hE;
    localparam logic [3:0] ALU_BGEU = 4'hF;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] str_ctrl;
        logic [4:0] rd;
    } m_ctrl_t;

endpackage

// File: rtl/execute_md_if.sv
// D/E inputs and E/M outputs of the execute stage bundled as one interface.
interface execute_md_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4
);
    logic               validE, flushE;
    logic               RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JalrE;
    logic [2:0]         strCtrlE;
    logic [ALUOP_W-1:0] ALUopE;
    logic [1:0]         SrcASelE, SrcBSelE, FwdAE, FwdBE;
    logic               MulDivE;
    logic [2:0]         MulDivOpE;
    logic [4:0]         rdE;
    logic [XLEN-1:0]    immE, PCE, r1E, r2E, ResultW;
    logic               stallE, PCsrcE;
    logic [XLEN-1:0]    PCplusImmE;
    logic               RegWriteM, MemWriteM, MemtoRegM, validM;
    logic [2:0]         strCtrlM;
    logic [4:0]         rdM;
    logic [XLEN-1:0]    ALUoutM, r2M;

    modport slave (
        input  validE, flushE, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JalrE,
               strCtrlE, ALUopE, SrcASelE, SrcBSelE, FwdAE, FwdBE, MulDivE,
               MulDivOpE, rdE, immE, PCE, r1E, r2E, ResultW,
        output stallE, PCsrcE, PCplusImmE, RegWriteM, MemWriteM, MemtoRegM,
               validM, strCtrlM, rdM, ALUoutM, r2M
    );

    modport master (
        output validE, flushE, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JalrE,
               strCtrlE, ALUopE, SrcASelE, SrcBSelE, FwdAE, FwdBE, MulDivE,
               MulDivOpE, rdE, immE, PCE, r1E, r2E, ResultW,
        input  stallE, PCsrcE, PCplusImmE, RegWriteM, MemWriteM, MemtoRegM,
               validM, strCtrlM, rdM, ALUoutM, r2M
    );
endinterface

// File: rtl/alu.sv
// Single-cycle integer ALU; branch_o is the compare outcome for branch ops, 1 otherwise.
module alu
    import execute_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic [ALUOP_W-1:0] op_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    output logic [XLEN-1:0]    y_o,
    output logic               branch_o
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           eq, lt, ltu;

    assign shamt = b_i[SHW-1:0];
    assign eq    = (a_i == b_i);
    assign lt    = ($signed(a_i) < $signed(b_i));
    assign ltu   = (a_i < b_i);

    always_comb begin
        y_o      = '0;
        branch_o = 1'b1;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = XLEN'(lt);
            ALU_SLTU: y_o = XLEN'(ltu);
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = XLEN'($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_BEQ:  begin branch_o = eq;   y_o = XLEN'(eq);   end
            ALU_BNE:  begin branch_o = ~eq;  y_o = XLEN'(~eq);  end
            ALU_BLT:  begin branch_o = lt;   y_o = XLEN'(lt);   end
            ALU_BGE:  begin branch_o = ~lt;  y_o = XLEN'(~lt);  end
            ALU_BLTU: begin branch_o = ltu;  y_o = XLEN'(ltu);  end
            ALU_BGEU: begin branch_o = ~ltu; y_o = XLEN'(~ltu); end
            default:  y_o = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV-M unit: unsigned shift-add multiply / restoring divide on operand
// magnitudes, XLEN steps in RUN, sign fix-up applied while in DONE.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [1:0]      state_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d, hi_q, hi_d, neg_q, neg_d, bz_q, bz_d;

    logic              sa, sb;
    logic [XLEN-1:0]   am, bm, half;
    logic [XLEN:0]     mac, rtry, rdiff;
    logic [2*XLEN-1:0] pfix;

    // Operand sign flags and magnitudes
    always_comb begin
        sa = a_i[XLEN-1] & (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        sb = b_i[XLEN-1] & (op_i inside {MD_MULH, MD_DIV, MD_REM});
        am = sa ? -a_i : a_i;
        bm = sb ? -b_i : b_i;
    end

    // One iteration: p_q holds {hi, lo} = {acc, multiplier} or {remainder, dividend/quotient}
    assign mac   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign rtry  = p_q[2*XLEN-1:XLEN-1];
    assign rdiff = rtry - {1'b0, b_q};

    // Divide by zero keeps the natural remainder but forces the quotient to all-ones
    always_comb begin
        pfix     = neg_q ? -p_q : p_q;
        half     = hi_q ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
        result_o = hi_q ? pfix[2*XLEN-1:XLEN] : pfix[XLEN-1:0];
        if (div_q) begin
            result_o = neg_q ? -half : half;
            if (bz_q && !hi_q) result_o = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        div_d   = div_q;
        hi_d    = hi_q;
        neg_d   = neg_q;
        bz_d    = bz_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_RUN;
                cnt_d   = CW'(XLEN);
                p_d     = {{XLEN{1'b0}}, am};
                b_d     = bm;
                div_d   = op_i[2];
                hi_d    = op_i[2] ? op_i[1] : (op_i[1:0] != 2'b00);
                neg_d   = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
                bz_d    = (b_i == '0);
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!div_q)
                    p_d = {mac, p_q[XLEN-1:1]};
                else if (rdiff[XLEN])
                    p_d = {rtry[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
                else
                    p_d = {rdiff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            hi_q    <= 1'b0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            neg_q   <= neg_d;
            bz_q    <= bz_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/execute_md.sv
// Execute stage: forwarding, ALU or iterative mul/div, branch target, and the
// registered E/M boundary that loads bubbles while stalled, flushed or invalid.
module execute_md
    import execute_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ALUOP_W   = 4,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    execute_md_if.slave   e_if
);
    logic [XLEN-1:0] fa, fb, src_a, src_b, alu_y, md_y, target;
    logic            alu_br, md_sel, md_start, stall, bubble;
    logic [1:0]      md_state;
    m_ctrl_t         ctrl_q, ctrl_d;
    logic [XLEN-1:0] aluout_q, aluout_d, r2_q, r2_d;

    // Forwarding muxes and ALU operand selection
    always_comb begin
        case (e_if.FwdAE)
            FWD_M:   fa = aluout_q;
            FWD_W:   fa = e_if.ResultW;
            default: fa = e_if.r1E;
        endcase
        case (e_if.FwdBE)
            FWD_M:   fb = aluout_q;
            FWD_W:   fb = e_if.ResultW;
            default: fb = e_if.r2E;
        endcase
        case (e_if.SrcASelE)
            SRCA_PC:  src_a = e_if.PCE;
            SRCA_RS1: src_a = fa;
            default:  src_a = '0;
        endcase
        case (e_if.SrcBSelE)
            SRCB_RS2:  src_b = fb;
            SRCB_IMM:  src_b = e_if.immE;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = '0;
        endcase
        target = (e_if.JalrE ? fa : e_if.PCE) + e_if.immE;
        if (e_if.JalrE) target[0] = 1'b0;
    end

    alu #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) u_alu (
        .op_i     (e_if.ALUopE),
        .a_i      (src_a),
        .b_i      (src_b),
        .y_o      (alu_y),
        .branch_o (alu_br)
    );

    assign md_sel   = MULDIV_EN & e_if.MulDivE;
    assign md_start = e_if.validE & md_sel & ~e_if.flushE;

    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .flush_i  (e_if.flushE),
        .op_i     (e_if.MulDivOpE),
        .a_i      (fa),
        .b_i      (fb),
        .state_o  (md_state),
        .result_o (md_y)
    );

    assign stall  = md_start & (md_state != ST_DONE) & ~rst;
    assign bubble = ~e_if.validE | e_if.flushE | stall;

    // Data fields hold during bubbles so no partial mul/div value is exposed
    always_comb begin
        ctrl_d   = '0;
        aluout_d = aluout_q;
        r2_d     = r2_q;
        if (!bubble) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.reg_write  = e_if.RegWriteE;
            ctrl_d.mem_write  = e_if.MemWriteE;
            ctrl_d.mem_to_reg = e_if.MemtoRegE;
            ctrl_d.str_ctrl   = e_if.strCtrlE;
            ctrl_d.rd         = e_if.rdE;
            aluout_d          = md_sel ? md_y : alu_y;
            r2_d              = fb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            aluout_q <= '0;
            r2_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            aluout_q <= aluout_d;
            r2_q     <= r2_d;
        end
    end

    assign e_if.stallE     = stall;
    assign e_if.PCsrcE     = e_if.validE & ~e_if.flushE & e_if.PCBranchE & alu_br;
    assign e_if.PCplusImmE = target;
    assign e_if.validM     = ctrl_q.valid;
    assign e_if.RegWriteM  = ctrl_q.reg_write;
    assign e_if.MemWriteM  = ctrl_q.mem_write;
    assign e_if.MemtoRegM  = ctrl_q.mem_to_reg;
    assign e_if.strCtrlM   = ctrl_q.str_ctrl;
    assign e_if.rdM        = ctrl_q.rd;
    assign e_if.ALUoutM    = aluout_q;
    assign e_if.r2M        = r2_q;
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: ALU path, forwarding, branch targets, mul/div
// results and latency, flush and mid-operation reset.
module tb_execute_md;
    import execute_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    execute_md_if #(.XLEN(XLEN), .ALUOP_W(4)) e_if ();

    execute_md #(.XLEN(XLEN), .ALUOP_W(4), .MULDIV_EN(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .e_if (e_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        e_if.validE = 1'b0; e_if.flushE = 1'b0;
        e_if.RegWriteE = 1'b0; e_if.MemWriteE = 1'b0; e_if.MemtoRegE = 1'b0;
        e_if.PCBranchE = 1'b0; e_if.JalrE = 1'b0; e_if.strCtrlE = 3'd0;
        e_if.ALUopE = ALU_ADD; e_if.SrcASelE = SRCA_RS1; e_if.SrcBSelE = SRCB_RS2;
        e_if.FwdAE = 2'b00; e_if.FwdBE = 2'b00; e_if.MulDivE = 1'b0; e_if.MulDivOpE = MD_MUL;
        e_if.rdE = 5'd0; e_if.immE = '0; e_if.PCE = '0; e_if.r1E = '0; e_if.r2E = '0;
        e_if.ResultW = '0;
    endtask

    task automatic set_add(input logic [31:0] a, input logic [31:0] b);
        set_nop();
        e_if.validE = 1'b1; e_if.RegWriteE = 1'b1; e_if.rdE = 5'd3;
        e_if.r1E = a; e_if.r2E = b;
    endtask

    // Drives one RV-M op until the stall drops, then lets it retire
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int stalls, output bit bub_bad);
        set_nop();
        e_if.validE = 1'b1; e_if.RegWriteE = 1'b1; e_if.rdE = 5'd7;
        e_if.MulDivE = 1'b1; e_if.MulDivOpE = op; e_if.r1E = a; e_if.r2E = b;
        #1;
        stalls  = 0;
        bub_bad = 1'b0;
        while (e_if.stallE === 1'b1 && stalls < 100) begin
            tick();
            stalls++;
            if (e_if.RegWriteM !== 1'b0 || e_if.validM !== 1'b0) bub_bad = 1'b1;
        end
        tick();
        res = e_if.ALUoutM;
        set_nop();
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        e_if.validE = 1'b1; e_if.MulDivE = 1'b1; e_if.RegWriteE = 1'b1;
        #1;
        tests++; if (e_if.stallE !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", e_if.stallE); end
        tick();
        tests++; if (e_if.validM !== 1'b0 || e_if.RegWriteM !== 1'b0 || e_if.ALUoutM !== 32'h0 || e_if.r2M !== 32'h0) begin
            fails++; $display("FAIL reset_outputs: validM=%b RegWriteM=%b ALUoutM=%h r2M=%h expected all 0",
                              e_if.validM, e_if.RegWriteM, e_if.ALUoutM, e_if.r2M);
        end
        rst = 1'b0;
        set_nop();
    endtask

    task automatic test_alu_add();
        set_add(32'd5, 32'd7);
        #1;
        tests++; if (e_if.stallE !== 1'b0) begin fails++; $display("FAIL add_stall: got %b expected 0", e_if.stallE); end
        tick();
        tests++; if (e_if.ALUoutM !== 32'd12) begin fails++; $display("FAIL add_result: got %h expected %h", e_if.ALUoutM, 32'd12); end
        tests++; if (e_if.validM !== 1'b1 || e_if.RegWriteM !== 1'b1 || e_if.rdM !== 5'd3 || e_if.r2M !== 32'd7) begin
            fails++; $display("FAIL add_ctrl: validM=%b RegWriteM=%b rdM=%0d r2M=%h expected 1 1 3 7",
                              e_if.validM, e_if.RegWriteM, e_if.rdM, e_if.r2M);
        end
        e_if.validE = 1'b0;
        tick();
        tests++; if (e_if.validM !== 1'b0 || e_if.RegWriteM !== 1'b0) begin
            fails++; $display("FAIL invalid_bubble: validM=%b RegWriteM=%b expected 0 0", e_if.validM, e_if.RegWriteM);
        end
        set_nop();
    endtask

    task automatic test_forward();
        set_add(32'd60, 32'd40);
        tick();
        tests++; if (e_if.ALUoutM !== 32'd100) begin fails++; $display("FAIL fwd_setup: got %h expected %h", e_if.ALUoutM, 32'd100); end
        set_add(32'd1, 32'd0);
        e_if.FwdAE = FWD_M; e_if.SrcBSelE = SRCB_IMM; e_if.immE = 32'd3;
        tick();
        tests++; if (e_if.ALUoutM !== 32'd103) begin fails++; $display("FAIL fwd_m: got %h expected %h", e_if.ALUoutM, 32'd103); end
        set_add(32'd9, 32'd1);
        e_if.FwdBE = FWD_W; e_if.ResultW = 32'h55; e_if.SrcASelE = 2'b01;
        tick();
        tests++; if (e_if.ALUoutM !== 32'h55 || e_if.r2M !== 32'h55) begin
            fails++; $display("FAIL fwd_w: ALUoutM=%h r2M=%h expected 55 55", e_if.ALUoutM, e_if.r2M);
        end
        set_nop();
    endtask

    task automatic test_branch();
        set_nop();
        e_if.validE = 1'b1; e_if.PCBranchE = 1'b1; e_if.JalrE = 1'b1;
        e_if.r1E = 32'h1003; e_if.immE = 32'd4; e_if.PCE = 32'h200;
        e_if.SrcASelE = SRCA_PC; e_if.SrcBSelE = SRCB_FOUR; e_if.RegWriteE = 1'b1;
        #1;
        tests++; if (e_if.PCplusImmE !== 32'h1006) begin fails++; $display("FAIL jalr_target: got %h expected %h", e_if.PCplusImmE, 32'h1006); end
        tests++; if (e_if.PCsrcE !== 1'b1) begin fails++; $display("FAIL jalr_taken: got %b expected 1", e_if.PCsrcE); end
        tick();
        tests++; if (e_if.ALUoutM !== 32'h204) begin fails++; $display("FAIL jalr_link: got %h expected %h", e_if.ALUoutM, 32'h204); end
        e_if.flushE = 1'b1;
        #1;
        tests++; if (e_if.PCsrcE !== 1'b0) begin fails++; $display("FAIL jalr_flush: got %b expected 0", e_if.PCsrcE); end
        tick();
        tests++; if (e_if.validM !== 1'b0) begin fails++; $display("FAIL jalr_flush_bubble: got %b expected 0", e_if.validM); end
        set_nop();
        e_if.validE = 1'b1; e_if.PCBranchE = 1'b1; e_if.ALUopE = ALU_BEQ;
        e_if.PCE = 32'h100; e_if.immE = 32'h20; e_if.r1E = 32'd5; e_if.r2E = 32'd5;
        #1;
        tests++; if (e_if.PCsrcE !== 1'b1 || e_if.PCplusImmE !== 32'h120) begin
            fails++; $display("FAIL beq_taken: PCsrcE=%b target=%h expected 1 120", e_if.PCsrcE, e_if.PCplusImmE);
        end
        e_if.r2E = 32'd6;
        #1;
        tests++; if (e_if.PCsrcE !== 1'b0) begin fails++; $display("FAIL beq_not_taken: got %b expected 0", e_if.PCsrcE); end
        e_if.ALUopE = ALU_BLT; e_if.r1E = 32'hFFFF_FFFF; e_if.r2E = 32'd1;
        #1;
        tests++; if (e_if.PCsrcE !== 1'b1) begin fails++; $display("FAIL blt_signed: got %b expected 1", e_if.PCsrcE); end
        set_nop();
    endtask

    task automatic test_muldiv();
        logic [31:0] res;
        int          st;
        bit          bb;
        logic [2:0]  ops [10] = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV,
                                  MD_REM, MD_DIV, MD_REMU, MD_DIVU, MD_REM};
        logic [31:0] va  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h8000_0000, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'hFFFF_FFFB};
        logic [31:0] vb  [10] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0};
        logic [31:0] exp [10] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000,
                                  32'h0, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        for (int i = 0; i < 10; i++) begin
            run_md(ops[i], va[i], vb[i], res, st, bb);
            tests++; if (res !== exp[i]) begin fails++; $display("FAIL md_result[%0d]: got %h expected %h", i, res, exp[i]); end
            tests++; if (st !== 33) begin fails++; $display("FAIL md_stall_cycles[%0d]: got %0d expected 33", i, st); end
            tests++; if (bb !== 1'b0) begin fails++; $display("FAIL md_bubble[%0d]: got %b expected 0", i, bb); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          st;
        bit          bb;
        set_nop();
        e_if.validE = 1'b1; e_if.RegWriteE = 1'b1; e_if.MulDivE = 1'b1;
        e_if.MulDivOpE = MD_DIV; e_if.r1E = 32'd100; e_if.r2E = 32'd7;
        repeat (10) tick();
        tests++; if (e_if.stallE !== 1'b1) begin fails++; $display("FAIL flush_pre_stall: got %b expected 1", e_if.stallE); end
        e_if.flushE = 1'b1;
        #1;
        tests++; if (e_if.stallE !== 1'b0) begin fails++; $display("FAIL flush_stall_drop: got %b expected 0", e_if.stallE); end
        tick();
        tests++; if (e_if.validM !== 1'b0 || e_if.RegWriteM !== 1'b0) begin
            fails++; $display("FAIL flush_bubble: validM=%b RegWriteM=%b expected 0 0", e_if.validM, e_if.RegWriteM);
        end
        set_add(32'd20, 32'd22);
        #1;
        tests++; if (e_if.stallE !== 1'b0) begin fails++; $display("FAIL flush_next_stall: got %b expected 0", e_if.stallE); end
        tick();
        tests++; if (e_if.ALUoutM !== 32'd42 || e_if.validM !== 1'b1) begin
            fails++; $display("FAIL flush_next_add: ALUoutM=%h validM=%b expected 2a 1", e_if.ALUoutM, e_if.validM);
        end
        run_md(MD_DIV, 32'd100, 32'd7, res, st, bb);
        tests++; if (res !== 32'd14 || st !== 33) begin
            fails++; $display("FAIL flush_restart: result=%h stalls=%0d expected e 33", res, st);
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res;
        int          st;
        bit          bb;
        set_nop();
        e_if.validE = 1'b1; e_if.RegWriteE = 1'b1; e_if.MulDivE = 1'b1; e_if.rdE = 5'd4;
        e_if.MulDivOpE = MD_MUL; e_if.r1E = 32'd6; e_if.r2E = 32'd7;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        tests++; if (e_if.stallE !== 1'b0) begin fails++; $display("FAIL rst_mid_stall: got %b expected 0", e_if.stallE); end
        tick();
        tests++; if (e_if.ALUoutM !== 32'h0 || e_if.r2M !== 32'h0 || e_if.validM !== 1'b0 || e_if.rdM !== 5'd0) begin
            fails++; $display("FAIL rst_mid_clear: ALUoutM=%h r2M=%h validM=%b rdM=%0d expected all 0",
                              e_if.ALUoutM, e_if.r2M, e_if.validM, e_if.rdM);
        end
        rst = 1'b0;
        run_md(MD_MUL, 32'd6, 32'd7, res, st, bb);
        tests++; if (res !== 32'd42 || st !== 33) begin
            fails++; $display("FAIL rst_mid_restart: result=%h stalls=%0d expected 2a 33", res, st);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_nop();
        test_reset();
        test_alu_add();
        test_forward();
        test_branch();
        test_muldiv();
        test_flush();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised next-generation execute stage for the 5-stage pipeline, sitting between the D/E and E/M pipeline registers.
- Adds operand forwarding, an iterative RV-M multiply/divide unit with stall, flush/bubble handling, and JALR target LSB clearing.
- Reuses the existing single-cycle alu sub-module and keeps the registered E/M boundary.

Parameters:
- XLEN, 32, datapath width; must be even and at least 8.
- ALUOP_W, 4, ALU opcode width.
- MULDIV_EN, 1, enables the multiply/divide unit. When 0, MulDivE is ignored and the instruction goes through the ALU.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- validE  in  1  E-stage instruction valid
- flushE  in  1  kill the E-stage instruction and abort any mul/div in progress
- RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JalrE  in  1 each  control bits
- strCtrlE  in  3  load/store width control
- ALUopE  in  ALUOP_W  ALU operation
- SrcASelE  in  2  operand A select: 00 PC, 01 zero, 11 rs1, 10 zero
- SrcBSelE  in  2  operand B select: 00 rs2, 01 imm, 10 constant 4, 11 zero
- FwdAE, FwdBE  in  2 each  forwarding select: 00 register file, 01 ALUoutM, 10 ResultW, 11 register file
- MulDivE  in  1  instruction is RV-M
- MulDivOpE  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rdE  in  5  destination register
- immE, PCE, r1E, r2E, ResultW  in  XLEN each  immediate, PC, register-file reads, writeback value
- stallE  out  1  hold the F/D/E stages this cycle
- PCsrcE  out  1  branch/jump taken
- PCplusImmE  out  XLEN  branch/jump target
- RegWriteM, MemWriteM, MemtoRegM, validM  out  1 each  registered control to the M stage
- strCtrlM  out  3  registered load/store control
- rdM  out  5  registered destination register
- ALUoutM, r2M  out  XLEN each  registered result and store data

Behaviour:
- Reset: on the first rising edge with rst=1, all M outputs are 0 and the FSM goes to IDLE. stallE is 0 while rst=1.
- Forwarding:
  - fA = FwdAE-selected value replacing r1E; fB = FwdBE-selected value replacing r2E.
  - fA and fB feed srcA/srcB and the mul/div unit.
  - fB feeds r2M.
- Target: PCplusImmE = (JalrE ? fA : PCE) + immE. When JalrE=1, bit 0 is forced to 0.
- PCsrcE = validE & ~flushE & PCBranchE & alu.branch. It is purely combinational.
- ALU path (MulDivE=0 or MULDIV_EN=0): single cycle. The M registers capture the ALU result and controls at the next edge.
- Mul/div FSM, states IDLE, RUN, DONE:
  - IDLE: if validE & MulDivE & ~flushE, latch operand magnitudes and sign flags, set counter=XLEN, go to RUN.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, counter decrements. At counter==1, go to DONE.
  - DONE: result is presented, go to IDLE.
- stallE = validE & MulDivE & ~flushE & (state != DONE). It is high for XLEN+1 cycles; the result is registered into ALUoutM at the end of the DONE cycle. Total E occupancy is XLEN+2 cycles.
- While stallE=1, the M registers load a bubble: RegWriteM=MemWriteM=MemtoRegM=validM=0, with the other fields don't-care.
- flushE in any state: FSM goes to IDLE, the M registers load a bubble, and no partial result reaches ALUoutM.
- Arithmetic:
  - Signed results are obtained by negating magnitude results.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (DIV of −2^(XLEN−1) by −1): quotient = dividend, remainder = 0.
  - Both edge cases still take the full XLEN+2 cycles.
- validE=0: the M registers load a bubble and the FSM does not start.
- rst asserted mid-operation: the FSM returns to IDLE and the partial result is discarded.

Decomposition:
- Shared package execute_pkg holds:
  - SrcA/SrcB/Fwd select encodings
  - MulDivOp encodings
  - FSM state encoding
- Sub-module muldiv_iter (FSM, counter, accumulators, sign fix-up) is instantiated once beside alu. The forwarding, target and pipeline-register logic stays in execute_md.

Test Plan:
- ADD with SrcA=11, SrcB=00, r1E=5, r2E=7 -> ALUoutM=12 one edge later, stallE=0 throughout.
- FwdAE=01 with ALUoutM=100, r1E=1, immE=3, ADD, SrcB=01 -> ALUoutM=103.
- MUL with fA=−3, fB=7 -> stallE high for 33 cycles, ALUoutM=0xFFFFFFEB after cycle 34, bubbles (RegWriteM=0) during the stall.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> ALUoutM=0xFFFFFFFE. DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000. REMU with 9 / 0 -> 9.
- JALR with fA=0x1003, immE=4, JalrE=1, branch taken -> PCplusImmE=0x1006, PCsrcE=1. The same instruction with flushE=1 -> PCsrcE=0.
- DIV, then flushE at RUN cycle 10 -> stallE drops the same cycle, validM=0, the FSM is in IDLE, and the next ADD completes normally. rst pulsed mid-RUN gives the same result and clears all outputs.
